spi_flash_arbiter: RTL and testbench

//  Shares the single W25Q32 SPI flash between two masters: the page loader (LDR, real-time bubble page

---
 rtl/spi_flash_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_spi_flash_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_arbiter.sv
// -----------------------------------------------------------------------------
// spi_flash_arbiter
//   Shares one SPI flash between the page loader (LDR, high priority) and an
//   auxiliary master (AUX, background). Whole nCS frames are granted; a fixed
//   guard time with idle pads separates any two owners, and a hold watchdog
//   reclaims the flash from a master that never lets go. Only drive-side pad
//   signals pass through here; flash input data fans out to both masters
//   outside this block.
//
// Ports
//   MCLK, nRESET                 clock (rising edge), async active-low reset
//   nREQ_LDR / nREQ_AUX          ownership requests, low = request
//   LDR_* / AUX_*                each master's nCS, CLK, IO0_DO, IO0_OE
//   nGNT_LDR / nGNT_AUX          ownership grants, low = owns the flash
//   AUXBLOCK                     high = no new AUX grants (existing one kept)
//   nROMCS, ROMCLK,
//   ROMIO0_DO, ROMIO0_OE         flash pad drive signals
//   TIMEOUT                      one-cycle pulse when the watchdog revokes a grant
//
// Parameters
//   GUARD_CYCLES  cycles of idle pads between grants (>= 1)
//   HOLD_W        watchdog width; a grant is revoked when the count hits all-ones
//   AUX_STARVE    AUX wait cycles after which AUX wins one contested arbitration
// -----------------------------------------------------------------------------
// state      | meaning
// -----------+------------------------------------------------------------------
// S_IDLE     | no owner, pads idle, arbitrate eligible requests
// S_GNT_LDR  | LDR owns the flash, pads follow LDR
// S_GNT_AUX  | AUX owns the flash, pads follow AUX
// S_GUARD    | post-release guard, pads idle, no grant for GUARD_CYCLES cycles
// -----------------------------------------------------------------------------
module spi_flash_arbiter #(
  parameter int GUARD_CYCLES = 4,
  parameter int HOLD_W       = 20,
  parameter int AUX_STARVE   = 4096
) (
  input  logic MCLK,
  input  logic nRESET,

  input  logic nREQ_LDR,
  input  logic LDR_nCS,
  input  logic LDR_CLK,
  input  logic LDR_IO0_DO,
  input  logic LDR_IO0_OE,
  output logic nGNT_LDR,

  input  logic nREQ_AUX,
  input  logic AUX_nCS,
  input  logic AUX_CLK,
  input  logic AUX_IO0_DO,
  input  logic AUX_IO0_OE,
  output logic nGNT_AUX,

  input  logic AUXBLOCK,

  output logic nROMCS,
  output logic ROMCLK,
  output logic ROMIO0_DO,
  output logic ROMIO0_OE,
  output logic TIMEOUT
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int SW = $clog2(AUX_STARVE + 1);

  localparam logic [GW-1:0]     GUARD_LOAD = GW'(GUARD_CYCLES - 1);
  localparam logic [SW-1:0]     STARVE_LIM = SW'(AUX_STARVE);
  // Last count before all-ones: the revoke happens on the edge that reaches all-ones.
  localparam logic [HOLD_W-1:0] HOLD_LAST  = {{(HOLD_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GNT_LDR = 2'd1,
    S_GNT_AUX = 2'd2,
    S_GUARD   = 2'd3
  } state_t;

  state_t              state;
  logic                sel_ldr;
  logic                sel_aux;
  logic [GW-1:0]       guard_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [SW-1:0]       starve_cnt;
  logic                rearm_ldr;
  logic                rearm_aux;

  logic ldr_elig;
  logic aux_elig;
  logic aux_starved;
  logic pick_ldr;
  logic pick_aux;

  assign ldr_elig    = !nREQ_LDR && rearm_ldr;
  assign aux_elig    = !nREQ_AUX && rearm_aux && !AUXBLOCK;
  assign aux_starved = (starve_cnt >= STARVE_LIM);
  assign pick_aux    = aux_elig && (!ldr_elig || aux_starved);
  assign pick_ldr    = ldr_elig && !pick_aux;

  // Pad mux: the select is registered, so an async reset idles the pads at once
  // and a master's nCS left low after release never reaches the pad.
  always_comb begin
    nROMCS    = 1'b1;
    ROMCLK    = 1'b0;
    ROMIO0_DO = 1'b0;
    ROMIO0_OE = 1'b0;
    if (sel_ldr) begin
      nROMCS    = LDR_nCS;
      ROMCLK    = LDR_CLK;
      ROMIO0_DO = LDR_IO0_DO;
      ROMIO0_OE = LDR_IO0_OE;
    end else if (sel_aux) begin
      nROMCS    = AUX_nCS;
      ROMCLK    = AUX_CLK;
      ROMIO0_DO = AUX_IO0_DO;
      ROMIO0_OE = AUX_IO0_OE;
    end
  end

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state      <= S_IDLE;
      sel_ldr    <= 1'b0;
      sel_aux    <= 1'b0;
      nGNT_LDR   <= 1'b1;
      nGNT_AUX   <= 1'b1;
      TIMEOUT    <= 1'b0;
      guard_cnt  <= '0;
      hold_cnt   <= '0;
      starve_cnt <= '0;
      rearm_ldr  <= 1'b1;
      rearm_aux  <= 1'b1;
    end else begin
      TIMEOUT <= 1'b0;

      // A master that timed out must show a released request before it can win again.
      if (nREQ_LDR) rearm_ldr <= 1'b1;
      if (nREQ_AUX) rearm_aux <= 1'b1;

      if (state == S_IDLE && pick_aux) begin
        starve_cnt <= '0;
      end else if (!nREQ_AUX && state != S_GNT_AUX && starve_cnt < STARVE_LIM) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (pick_ldr) begin
            state    <= S_GNT_LDR;
            sel_ldr  <= 1'b1;
            nGNT_LDR <= 1'b0;
            hold_cnt <= '0;
          end else if (pick_aux) begin
            state    <= S_GNT_AUX;
            sel_aux  <= 1'b1;
            nGNT_AUX <= 1'b0;
            hold_cnt <= '0;
          end
        end

        S_GNT_LDR: begin
          if (nREQ_LDR || hold_cnt == HOLD_LAST) begin
            state     <= S_GUARD;
            sel_ldr   <= 1'b0;
            nGNT_LDR  <= 1'b1;
            guard_cnt <= GUARD_LOAD;
            if (!nREQ_LDR) begin
              TIMEOUT   <= 1'b1;
              rearm_ldr <= 1'b0;
              hold_cnt  <= hold_cnt + 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        S_GNT_AUX: begin
          if (nREQ_AUX || hold_cnt == HOLD_LAST) begin
            state     <= S_GUARD;
            sel_aux   <= 1'b0;
            nGNT_AUX  <= 1'b1;
            guard_cnt <= GUARD_LOAD;
            if (!nREQ_AUX) begin
              TIMEOUT   <= 1'b1;
              rearm_aux <= 1'b0;
              hold_cnt  <= hold_cnt + 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        S_GUARD: begin
          if (guard_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            guard_cnt <= guard_cnt - 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          sel_ldr  <= 1'b0;
          sel_aux  <= 1'b0;
          nGNT_LDR <= 1'b1;
          nGNT_AUX <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_arbiter
//   Bench for spi_flash_arbiter with GUARD_CYCLES=4, HOLD_W=4, AUX_STARVE=8.
//   Expected grant owners are queued as requests are driven and popped when a
//   new grant appears; timing and pad behaviour are checked inline.
// -----------------------------------------------------------------------------
module tb_spi_flash_arbiter;

  localparam int GUARD  = 4;
  localparam int HW     = 4;
  localparam int STARVE = 8;

  logic MCLK = 1'b0;
  logic nRESET;
  logic nREQ_LDR, LDR_nCS, LDR_CLK, LDR_IO0_DO, LDR_IO0_OE, nGNT_LDR;
  logic nREQ_AUX, AUX_nCS, AUX_CLK, AUX_IO0_DO, AUX_IO0_OE, nGNT_AUX;
  logic AUXBLOCK;
  logic nROMCS, ROMCLK, ROMIO0_DO, ROMIO0_OE, TIMEOUT;

  int total = 0;
  int bad   = 0;
  int sb[$];
  logic prev_idle = 1'b1;

  spi_flash_arbiter #(
    .GUARD_CYCLES(GUARD),
    .HOLD_W      (HW),
    .AUX_STARVE  (STARVE)
  ) dut (
    .MCLK      (MCLK),
    .nRESET    (nRESET),
    .nREQ_LDR  (nREQ_LDR),
    .LDR_nCS   (LDR_nCS),
    .LDR_CLK   (LDR_CLK),
    .LDR_IO0_DO(LDR_IO0_DO),
    .LDR_IO0_OE(LDR_IO0_OE),
    .nGNT_LDR  (nGNT_LDR),
    .nREQ_AUX  (nREQ_AUX),
    .AUX_nCS   (AUX_nCS),
    .AUX_CLK   (AUX_CLK),
    .AUX_IO0_DO(AUX_IO0_DO),
    .AUX_IO0_OE(AUX_IO0_OE),
    .nGNT_AUX  (nGNT_AUX),
    .AUXBLOCK  (AUXBLOCK),
    .nROMCS    (nROMCS),
    .ROMCLK    (ROMCLK),
    .ROMIO0_DO (ROMIO0_DO),
    .ROMIO0_OE (ROMIO0_OE),
    .TIMEOUT   (TIMEOUT)
  );

  always #5 MCLK = ~MCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  task automatic wait_gnt(input string tag, input bit aux, input int max);
    int k = 0;
    while (((aux ? nGNT_AUX : nGNT_LDR) !== 1'b0) && k < max) begin
      @(negedge MCLK);
      k++;
    end
    chk(tag, aux ? nGNT_AUX : nGNT_LDR, 0);
  endtask

  // Grant scoreboard (1 = LDR, 2 = AUX) and mutual-exclusion check.
  always @(negedge MCLK) begin
    if (nRESET) chk("excl", nGNT_LDR | nGNT_AUX, 1);
    if (prev_idle && (!nGNT_LDR || !nGNT_AUX)) begin
      if (sb.size() == 0) chk("sb_extra", sb.size(), 1);
      else chk("gnt_owner", nGNT_LDR ? 2 : 1, sb.pop_front());
    end
    prev_idle <= nGNT_LDR && nGNT_AUX;
  end

  initial begin
    int lows;
    nRESET   = 1'b0;
    nREQ_LDR = 1'b1; LDR_nCS = 1'b1; LDR_CLK = 1'b0; LDR_IO0_DO = 1'b0; LDR_IO0_OE = 1'b0;
    nREQ_AUX = 1'b1; AUX_nCS = 1'b1; AUX_CLK = 1'b0; AUX_IO0_DO = 1'b0; AUX_IO0_OE = 1'b0;
    AUXBLOCK = 1'b0;

    // Reset values
    cyc(2);
    chk("rst_gl", nGNT_LDR, 1);
    chk("rst_ga", nGNT_AUX, 1);
    chk("rst_cs", nROMCS, 1);
    chk("rst_clk", ROMCLK, 0);
    chk("rst_do", ROMIO0_DO, 0);
    chk("rst_oe", ROMIO0_OE, 0);
    chk("rst_to", TIMEOUT, 0);
    nRESET = 1'b1;

    // 1: single LDR request, one-cycle grant latency, pads follow LDR only
    cyc(10);
    nREQ_LDR = 1'b0; sb.push_back(1);
    #1 chk("t1_pre", nGNT_LDR, 1);
    cyc(1);
    chk("t1_gnt", nGNT_LDR, 0);
    chk("t1_noaux", nGNT_AUX, 1);
    AUX_nCS = 1'b0; AUX_CLK = 1'b1; AUX_IO0_DO = 1'b1; AUX_IO0_OE = 1'b0;
    LDR_nCS = 1'b0; LDR_IO0_OE = 1'b1;
    for (int i = 0; i < 6; i++) begin
      LDR_CLK = i[0]; LDR_IO0_DO = i[1];
      #1;
      chk("t1_clk", ROMCLK, i[0]);
      chk("t1_do", ROMIO0_DO, i[1]);
      chk("t1_cs", nROMCS, 0);
      chk("t1_oe", ROMIO0_OE, 1);
      cyc(1);
    end
    LDR_nCS = 1'b1; LDR_CLK = 1'b0; LDR_IO0_DO = 1'b0; LDR_IO0_OE = 1'b0;
    AUX_nCS = 1'b1; AUX_CLK = 1'b0; AUX_IO0_DO = 1'b0;
    nREQ_LDR = 1'b1;
    cyc(1);
    chk("t1_rel", nGNT_LDR, 1);
    cyc(6);

    // 2: simultaneous requests, LDR wins; LDR releases with nCS still low
    nREQ_LDR = 1'b0; nREQ_AUX = 1'b0;
    sb.push_back(1); sb.push_back(2);
    cyc(1);
    chk("t2_ldr", nGNT_LDR, 0);
    chk("t2_noaux", nGNT_AUX, 1);
    LDR_nCS = 1'b0;
    cyc(3);
    nREQ_LDR = 1'b1;
    // GUARD cycles plus the IDLE arbitration cycle before AUX is granted
    for (int k = 1; k <= GUARD + 1; k++) begin
      cyc(1);
      chk("t2_guard_cs", nROMCS, 1);
      chk("t2_guard_ga", nGNT_AUX, 1);
      chk("t2_guard_gl", nGNT_LDR, 1);
    end
    cyc(1);
    chk("t2_aux_gnt", nGNT_AUX, 0);
    LDR_nCS = 1'b1;
    AUX_nCS = 1'b0; AUX_IO0_OE = 1'b1;
    #1;
    chk("t2_aux_cs", nROMCS, 0);
    chk("t2_aux_oe", ROMIO0_OE, 1);
    cyc(1);
    AUX_nCS = 1'b1; AUX_IO0_OE = 1'b0; nREQ_AUX = 1'b1;
    cyc(7);

    // 3: AUXBLOCK gates new AUX grants but does not revoke one
    AUXBLOCK = 1'b1; nREQ_AUX = 1'b0;
    lows = 0;
    for (int k = 0; k < 1000; k++) begin
      cyc(1);
      if (!nGNT_AUX) lows++;
    end
    chk("t3_block", lows, 0);
    AUXBLOCK = 1'b0; sb.push_back(2);
    cyc(1);
    chk("t3_unblock", nGNT_AUX, 0);
    AUXBLOCK = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("t3_keep", nGNT_AUX, 0);
    end
    AUXBLOCK = 1'b0; nREQ_AUX = 1'b1;
    cyc(7);

    // 4: watchdog with HOLD_W=4 revokes at grant cycle 15, rearm required
    nREQ_LDR = 1'b0; sb.push_back(1);
    cyc(1);
    chk("t4_gnt", nGNT_LDR, 0);
    for (int k = 0; k < 14; k++) begin
      cyc(1);
      chk("t4_hold", nGNT_LDR, 0);
      chk("t4_to_early", TIMEOUT, 0);
    end
    cyc(1);
    chk("t4_timeout", TIMEOUT, 1);
    chk("t4_drop", nGNT_LDR, 1);
    cyc(1);
    chk("t4_pulse", TIMEOUT, 0);
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (!nGNT_LDR) lows++;
    end
    chk("t4_norearm", lows, 0);
    nREQ_LDR = 1'b1;
    cyc(1);
    chk("t4_rel_cyc", nGNT_LDR, 1);
    nREQ_LDR = 1'b0; sb.push_back(1);
    cyc(1);
    chk("t4_regrant", nGNT_LDR, 0);
    nREQ_LDR = 1'b1;
    cyc(7);

    // 5: AUX_STARVE=8, LDR back-to-back with AUX pending: order L, L, A, L
    nREQ_LDR = 1'b0; sb.push_back(1);
    cyc(1);
    chk("t5_g1", nGNT_LDR, 0);
    cyc(4);
    nREQ_LDR = 1'b1; nREQ_AUX = 1'b0;
    sb.push_back(1); sb.push_back(2); sb.push_back(1);
    cyc(1);
    nREQ_LDR = 1'b0;
    wait_gnt("t5_g2_ldr", 1'b0, 10);
    chk("t5_g2_noaux", nGNT_AUX, 1);
    cyc(10);
    nREQ_LDR = 1'b1;
    cyc(1);
    nREQ_LDR = 1'b0;
    wait_gnt("t5_g3_aux", 1'b1, 10);
    chk("t5_g3_noldr", nGNT_LDR, 1);
    cyc(3);
    nREQ_AUX = 1'b1;
    cyc(1);
    nREQ_AUX = 1'b0;
    wait_gnt("t5_g4_ldr", 1'b0, 10);
    chk("t5_g4_noaux", nGNT_AUX, 1);
    nREQ_AUX = 1'b1;
    cyc(2);
    nREQ_LDR = 1'b1;
    cyc(7);

    // 6: asynchronous reset during an AUX frame
    nREQ_AUX = 1'b0; sb.push_back(2);
    cyc(1);
    chk("t6_gnt", nGNT_AUX, 0);
    AUX_nCS = 1'b0; AUX_IO0_OE = 1'b1; AUX_CLK = 1'b1;
    #1;
    chk("t6_pre_cs", nROMCS, 0);
    chk("t6_pre_oe", ROMIO0_OE, 1);
    #1 nRESET = 1'b0;
    #1;
    chk("t6_rst_cs", nROMCS, 1);
    chk("t6_rst_gnt", nGNT_AUX, 1);
    chk("t6_rst_oe", ROMIO0_OE, 0);
    chk("t6_rst_clk", ROMCLK, 0);
    chk("t6_rst_to", TIMEOUT, 0);
    AUX_nCS = 1'b1; AUX_IO0_OE = 1'b0; AUX_CLK = 1'b0; nREQ_AUX = 1'b1;
    cyc(2);
    nRESET = 1'b1;
    cyc(3);
    chk("t6_after", nGNT_AUX, 1);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
